// File: rtl/sound_mem_arbiter.sv
// Shared sound-data memory front end: two AHB-lite-style read slaves
// (BGM and Sound) arbitrated onto one single-port synchronous-read memory.

// One read slave port: captures a read, waits for a grant, then holds the word.
module sound_mem_arbiter_port #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_haddr,
    input  logic [1:0]        i_htrans,
    input  logic              i_hwrite,
    input  logic              i_grant,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_pend,
    output logic [ADDR_W-1:0] o_addr,
    output logic [31:0]       o_hrdata,
    output logic              o_hready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_MEMW,
        ST_DONE
    } port_state_t;

    port_state_t        r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_hrdata;
    logic               r_hready;
    logic               w_capture;
    logic               w_unused;

    // Writes and idle/busy transfers are never captured; writes complete at once.
    assign w_capture = i_htrans[1] & ~i_hwrite;

    // Byte-lane bits, high address bits and HTRANS[0] carry no meaning here.
    assign w_unused = ^{i_haddr[31:ADDR_W+2], i_haddr[1:0], i_htrans[0]};

    // Per-port transaction FSM with registered HREADY and read data.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_hrdata <= '0;
            r_hready <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_capture) begin
                        r_addr   <= i_haddr[ADDR_W+1:2];
                        r_state  <= ST_PEND;
                        r_hready <= 1'b0;
                    end else begin
                        r_state  <= ST_IDLE;
                        r_hready <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (i_grant) begin
                        r_state <= ST_MEMW;
                    end
                end
                ST_MEMW: begin
                    // Memory returns data exactly one cycle after the grant.
                    r_hrdata <= i_mem_rdata;
                    r_state  <= ST_DONE;
                    r_hready <= 1'b1;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_hready <= 1'b1;
                end
            endcase
        end
    end

    assign o_pend   = (r_state == ST_PEND);
    assign o_addr   = r_addr;
    assign o_hrdata = r_hrdata;
    assign o_hready = r_hready;

endmodule

// Top level: two read ports plus the single-grant memory arbiter.
module sound_mem_arbiter #(
    parameter int ADDR_W      = 12,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       B_HADDR,
    input  logic [1:0]        B_HTRANS,
    input  logic              B_HWRITE,
    output logic [31:0]       B_HRDATA,
    output logic              B_HREADY,
    input  logic [31:0]       S_HADDR,
    input  logic [1:0]        S_HTRANS,
    input  logic              S_HWRITE,
    output logic [31:0]       S_HRDATA,
    output logic              S_HREADY,
    output logic              MEM_EN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [31:0]       MEM_RDATA
);

    logic              w_b_pend;
    logic              w_s_pend;
    logic [ADDR_W-1:0] w_b_addr;
    logic [ADDR_W-1:0] w_s_addr;
    logic              w_grant_b;
    logic              w_grant_s;
    logic              w_s_wins;
    logic              r_last_b;      // 1: last conflict was won by B
    logic [ADDR_W-1:0] r_mem_addr;    // holds MEM_ADDR while no grant

    sound_mem_arbiter_port #(.ADDR_W(ADDR_W)) u_port_b (
        .clk         (clk),
        .rst         (rst),
        .i_haddr     (B_HADDR),
        .i_htrans    (B_HTRANS),
        .i_hwrite    (B_HWRITE),
        .i_grant     (w_grant_b),
        .i_mem_rdata (MEM_RDATA),
        .o_pend      (w_b_pend),
        .o_addr      (w_b_addr),
        .o_hrdata    (B_HRDATA),
        .o_hready    (B_HREADY)
    );

    sound_mem_arbiter_port #(.ADDR_W(ADDR_W)) u_port_s (
        .clk         (clk),
        .rst         (rst),
        .i_haddr     (S_HADDR),
        .i_htrans    (S_HTRANS),
        .i_hwrite    (S_HWRITE),
        .i_grant     (w_grant_s),
        .i_mem_rdata (MEM_RDATA),
        .o_pend      (w_s_pend),
        .o_addr      (w_s_addr),
        .o_hrdata    (S_HRDATA),
        .o_hready    (S_HREADY)
    );

    // Grant selection: at most one pending port wins each cycle.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_s_wins  = 1'b1;
        w_grant_b = 1'b0;
        w_grant_s = 1'b0;
        if (ROUND_ROBIN) begin
            // On conflict, the port that lost the previous conflict goes first.
            w_s_wins = r_last_b;
        end
        w_grant_s = w_s_pend & (~w_b_pend | w_s_wins);
        w_grant_b = w_b_pend & (~w_s_pend | ~w_s_wins);
    end

    // Conflict history and held memory address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_b   <= 1'b1;
            r_mem_addr <= '0;
        end else begin
            if (w_b_pend && w_s_pend) begin
                r_last_b <= w_grant_b;
            end
            if (w_grant_s) begin
                r_mem_addr <= w_s_addr;
            end else if (w_grant_b) begin
                r_mem_addr <= w_b_addr;
            end
        end
    end

    assign MEM_EN   = w_grant_b | w_grant_s;
    assign MEM_ADDR = w_grant_s ? w_s_addr :
                      w_grant_b ? w_b_addr : r_mem_addr;

endmodule
